// File: rtl/pool2d_stream.sv
// Streaming 2x2 stride-2 pooling over a raster feature map, CHANNELS lanes in parallel.
// Define POOL_AVG_EN to add the avg_sel port and an average mode alongside max.
module pool2d_stream #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned CHANNELS = 1,
  parameter int unsigned WIDTH    = 26,
  parameter int unsigned HEIGHT   = 26,
  parameter bit          SIGNED   = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic [CHANNELS*DATA_W-1:0]   pixel_in,
`ifdef POOL_AVG_EN
  input  logic                         avg_sel,
`endif
  output logic [CHANNELS*DATA_W-1:0]   pool_out,
  output logic                         valid_out,
  output logic                         frame_done
);

  localparam int unsigned CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned RW  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned OW  = WIDTH / 2;
  localparam int unsigned OH  = HEIGHT / 2;
  localparam int unsigned LW  = (OW > 1) ? $clog2(OW) : 1;
`ifdef POOL_AVG_EN
  localparam int unsigned SW  = DATA_W + 1;
`else
  localparam int unsigned SW  = DATA_W;
`endif
  // Working width leaves headroom so unsigned sums stay positive when treated as signed.
  localparam int unsigned EW  = DATA_W + 3;
  localparam int unsigned DW  = CHANNELS * DATA_W;
  localparam int unsigned LBW = CHANNELS * SW;

  localparam logic [CW-1:0]        COL_LAST     = CW'(WIDTH - 1);
  localparam logic [RW-1:0]        ROW_LAST     = RW'(HEIGHT - 1);
  localparam logic [CW-1:0]        COL_OUT_LAST = CW'(2 * OW - 1);
  localparam logic [RW-1:0]        ROW_OUT_LAST = RW'(2 * OH - 1);
  localparam logic signed [EW-1:0] RND          = 2;

  logic [CW-1:0]  col_q;
  logic [RW-1:0]  row_q;
  logic [DW-1:0]  pair_q;
  logic [LBW-1:0] linebuf [OW];
  logic [LBW-1:0] lb_rd;
  logic [LBW-1:0] lb_wr;
  logic [DW-1:0]  pool_d;
  logic [LW-1:0]  lb_idx;
  logic           col_last;
  logic           row_last;
  logic           row_skip;
  logic           avg_mode;

  function automatic logic signed [EW-1:0] ext_d(input logic [DATA_W-1:0] v);
    if (SIGNED) return {{(EW-DATA_W){v[DATA_W-1]}}, v};
    else        return {{(EW-DATA_W){1'b0}}, v};
  endfunction

  function automatic logic signed [EW-1:0] ext_s(input logic [SW-1:0] v);
    if (SIGNED) return {{(EW-SW){v[SW-1]}}, v};
    else        return {{(EW-SW){1'b0}}, v};
  endfunction

  assign col_last = (col_q == COL_LAST);
  assign row_last = (row_q == ROW_LAST);
  // Trailing row of an odd-height frame must not overwrite the buffer.
  assign row_skip = (HEIGHT % 2 == 1) && row_last;
  assign lb_idx   = LW'(col_q >> 1);
  assign lb_rd    = linebuf[lb_idx];

`ifdef POOL_AVG_EN
  logic avg_q;
  // Mode is latched on the first beat of a frame and frozen until the next one.
  assign avg_mode = (col_q == '0 && row_q == '0) ? avg_sel : avg_q;
`else
  assign avg_mode = 1'b0;
`endif

  always_comb begin
    logic signed [EW-1:0] e_cur;
    logic signed [EW-1:0] e_pr;
    logic signed [EW-1:0] e_lb;
    logic signed [EW-1:0] part;
    logic signed [EW-1:0] full;
    lb_wr  = '0;
    pool_d = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      e_cur = ext_d(pixel_in[c*DATA_W +: DATA_W]);
      e_pr  = ext_d(pair_q[c*DATA_W +: DATA_W]);
      e_lb  = ext_s(lb_rd[c*SW +: SW]);
      if (avg_mode) begin
        part = e_pr + e_cur;
        full = e_lb + part;
        full = (full + RND) >>> 2;
      end else begin
        part = (e_pr > e_cur) ? e_pr : e_cur;
        full = (e_lb > part) ? e_lb : part;
      end
      lb_wr[c*SW +: SW]          = part[SW-1:0];
      pool_d[c*DATA_W +: DATA_W] = full[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q      <= '0;
      row_q      <= '0;
      pair_q     <= '0;
      pool_out   <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
`ifdef POOL_AVG_EN
      avg_q      <= 1'b0;
`endif
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      if (valid_in) begin
`ifdef POOL_AVG_EN
        avg_q <= avg_mode;
`endif
        if (col_last) begin
          col_q <= '0;
          row_q <= row_last ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
        if (!col_q[0]) begin
          pair_q <= pixel_in;
        end else if (row_q[0]) begin
          // Odd columns and odd rows are always inside the pooled region.
          pool_out   <= pool_d;
          valid_out  <= 1'b1;
          frame_done <= (col_q == COL_OUT_LAST) && (row_q == ROW_OUT_LAST);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (valid_in && col_q[0] && !row_q[0] && !row_skip) begin
      linebuf[lb_idx] <= lb_wr;
    end
  end

endmodule
